hazard_ctrl_unit: RTL and testbench

- Parametrised hazard and stall controller for the 5-stage pipelined RISC-V core (F/D/E/M/W).
- Generates E-stage operand forwarding selects, load-use stalls and taken-branch/jump flushes.
- Adds behaviour the core lacks today: a memory-wait FSM that freezes the whole pipeline while the data memory is not ready, with timeout and sticky error.
- Sits beside the datapath and controller; all stage enables and flushes come from this block.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/mem_wait_fsm.sv | 70 +++++++
 rtl/hazard_ctrl_unit.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/stall controller.
// Forwarding selects, result-source codes and memory-wait FSM states.
package hazard_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [1:0] RES_LOAD = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ERR  = 2'b10
    } mw_state_e;

endpackage

// File: rtl/mem_wait_fsm.sv
// Memory-wait FSM: freezes the pipeline while data memory is busy.
// Counts consecutive wait cycles; reaching MEM_TIMEOUT locks into ERR.
module mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic MemReq_M,
    input  logic MemReady_M,
    output logic mem_stall,
    output logic MemErr
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] ONE    = TO_W'(1);

    mw_state_e       state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_stall = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (MemReq_M && !MemReady_M) begin
                    mem_stall = 1'b1;
                    cnt_d     = ONE;
                    state_d   = (ONE == TO_LIM) ? ERR : WAIT;
                end
            end
            WAIT: begin
                // the ready cycle completes the access, so M may advance
                if (MemReady_M) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q + ONE;
                    if (cnt_d == TO_LIM) begin
                        state_d = ERR;
                    end
                end
            end
            ERR: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign MemErr = (state_q == ERR);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard/stall controller: forwarding, load-use, branch flush, memory wait.
// Optional perf counters enabled by HAZARD_PERF_EN.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic [REG_AW-1:0] Rs1_E,
    input  logic [REG_AW-1:0] Rs2_E,
    input  logic [REG_AW-1:0] Rd_E,
    input  logic [REG_AW-1:0] Rd_M,
    input  logic [REG_AW-1:0] Rd_W,
    input  logic              RegWrite_M,
    input  logic              RegWrite_W,
    input  logic [1:0]        ResultSrc_E,
    input  logic              PCSrc_E,
    input  logic              MemReq_M,
    input  logic              MemReady_M,
    output logic [1:0]        ForwardA_E,
    output logic [1:0]        ForwardB_E,
    output logic              Stall_F,
    output logic              Stall_D,
    output logic              Stall_E,
    output logic              Stall_M,
    output logic              Flush_D,
    output logic              Flush_E,
    output logic              Flush_W,
    output logic              MemErr,
    output logic [CNT_W-1:0]  PerfStall,
    output logic [CNT_W-1:0]  PerfFlush
);

    logic mem_stall;
    logic lw_stall;
    logic br_eff;
    logic lw_eff;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        logic [1:0] sel;
        sel = FWD_RF;
        if (rs != '0) begin
            if (RegWrite_M && (Rd_M == rs)) begin
                sel = FWD_MEM;
            end else if (RegWrite_W && (Rd_W == rs)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    mem_wait_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_mem_wait (
        .clk        (clk),
        .reset      (reset),
        .MemReq_M   (MemReq_M),
        .MemReady_M (MemReady_M),
        .mem_stall  (mem_stall),
        .MemErr     (MemErr)
    );

    assign lw_stall = (ResultSrc_E == RES_LOAD) && (Rd_E != '0)
                    && ((Rs1_D == Rd_E) || (Rs2_D == Rd_E));

    // memory wait masks branch, branch masks load-use
    assign br_eff = PCSrc_E && !mem_stall;
    assign lw_eff = lw_stall && !PCSrc_E && !mem_stall;

    always_comb begin
        ForwardA_E = FWD_RF;
        ForwardB_E = FWD_RF;
        Stall_F    = 1'b0;
        Stall_D    = 1'b0;
        Stall_E    = 1'b0;
        Stall_M    = 1'b0;
        Flush_D    = 1'b1;
        Flush_E    = 1'b1;
        Flush_W    = 1'b1;
        if (reset) begin
            ForwardA_E = fwd_sel(Rs1_E);
            ForwardB_E = fwd_sel(Rs2_E);
            Stall_F    = mem_stall || lw_eff;
            Stall_D    = mem_stall || lw_eff;
            Stall_E    = mem_stall;
            Stall_M    = mem_stall;
            Flush_D    = br_eff;
            Flush_E    = br_eff || lw_eff;
            Flush_W    = mem_stall;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] ps_q, ps_d;
    logic [CNT_W-1:0] pf_q, pf_d;
    logic             any_stall;
    logic             any_flush;

    assign any_stall = Stall_F || Stall_D || Stall_E || Stall_M;
    assign any_flush = Flush_D || Flush_E;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_q <= '0;
            pf_q <= '0;
        end else begin
            ps_q <= ps_d;
            pf_q <= pf_d;
        end
    end

    always_comb begin
        ps_d = ps_q;
        pf_d = pf_q;
        if (any_stall && (ps_q != '1)) begin
            ps_d = ps_q + CNT_W'(1);
        end
        if (any_flush && (pf_q != '1)) begin
            pf_d = pf_q + CNT_W'(1);
        end
    end

    assign PerfStall = ps_q;
    assign PerfFlush = pf_q;
`else
    assign PerfStall = '0;
    assign PerfFlush = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit (MEM_TIMEOUT=4).
// Table vectors plus multi-cycle sequences checked through a scoreboard.
module tb_hazard_ctrl_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic        RegWrite_M, RegWrite_W;
    logic [1:0]  ResultSrc_E;
    logic        PCSrc_E, MemReq_M, MemReady_M;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        Stall_F, Stall_D, Stall_E, Stall_M;
    logic        Flush_D, Flush_E, Flush_W, MemErr;
    logic [31:0] PerfStall, PerfFlush;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(
        .REG_AW(5), .MEM_TIMEOUT(4), .TO_W(8), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
        .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
        .Rd_M(Rd_M), .Rd_W(Rd_W),
        .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .ResultSrc_E(ResultSrc_E), .PCSrc_E(PCSrc_E),
        .MemReq_M(MemReq_M), .MemReady_M(MemReady_M),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .Stall_F(Stall_F), .Stall_D(Stall_D),
        .Stall_E(Stall_E), .Stall_M(Stall_M),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_W(Flush_W),
        .MemErr(MemErr), .PerfStall(PerfStall), .PerfFlush(PerfFlush)
    );

    // fa, fb, {sf,sd,se,sm}, {fd,fe,fw}, err
    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic [3:0] st;
        logic [2:0] fl;
        logic       err;
    } exp_t;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww;
        logic [1:0] rse;
        logic       pcs, req, rdy;
    } in_t;

    typedef struct { in_t i; exp_t e; string n; } vec_t;
    typedef struct { exp_t e; string n; } sb_t;

    sb_t sbq[$];
    int  total = 0;
    int  bad   = 0;

    function automatic exp_t mk(logic [1:0] fa, logic [1:0] fb,
                                logic [3:0] st, logic [2:0] fl,
                                logic err);
        exp_t e;
        e.fa = fa; e.fb = fb; e.st = st; e.fl = fl; e.err = err;
        return e;
    endfunction

    function automatic exp_t got();
        return mk(ForwardA_E, ForwardB_E,
                  {Stall_F, Stall_D, Stall_E, Stall_M},
                  {Flush_D, Flush_E, Flush_W}, MemErr);
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, act, req);
        end
    endtask

    task automatic drive(in_t v);
        Rs1_D = v.rs1d; Rs2_D = v.rs2d;
        Rs1_E = v.rs1e; Rs2_E = v.rs2e; Rd_E = v.rde;
        Rd_M = v.rdm; Rd_W = v.rdw;
        RegWrite_M = v.rwm; RegWrite_W = v.rww;
        ResultSrc_E = v.rse; PCSrc_E = v.pcs;
        MemReq_M = v.req; MemReady_M = v.rdy;
    endtask

    task automatic apply(in_t v, exp_t e, string n);
        sb_t s;
        @(posedge clk);
        #1;
        drive(v);
        s.e = e;
        s.n = n;
        sbq.push_back(s);
    endtask

    always @(negedge clk) begin
        sb_t s;
        if (sbq.size() > 0) begin
            s = sbq.pop_front();
            total++;
            if (got() !== s.e) begin
                bad++;
                $display("FAIL %s: got %b want %b", s.n, got(), s.e);
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            assert (!(PCSrc_E && ResultSrc_E == 2'b01 && Rd_E != 0
                      && (Rs1_D == Rd_E || Rs2_D == Rd_E)))
            else $error("stimulus drives branch and load-use together");
        end
    end

    in_t  z;
    exp_t E0, ST, BR, LW, RST;

    task automatic drain();
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic do_reset(string n);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(z);
        @(negedge clk);
        chk({n, "_bundle"}, 32'(got()), 32'(RST));
        chk({n, "_pstall"}, PerfStall, 32'd0);
        chk({n, "_pflush"}, PerfFlush, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        vec_t tbl[12];
        in_t  v;

        z = '{default: '0};
        E0  = mk(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0);
        ST  = mk(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0);
        BR  = mk(2'b00, 2'b00, 4'b0000, 3'b110, 1'b0);
        LW  = mk(2'b00, 2'b00, 4'b1100, 3'b010, 1'b0);
        RST = mk(2'b00, 2'b00, 4'b0000, 3'b111, 1'b0);

        tbl[0] = '{z, E0, "idle"};
        v = z; v.rwm = 1; v.rdm = 5; v.rs1e = 5; v.rww = 1; v.rdw = 5;
        tbl[1] = '{v, mk(2'b10, 2'b00, 4'h0, 3'b000, 0), "fwdA_m_beats_w"};
        v = z; v.rwm = 1; v.rww = 1;
        tbl[2] = '{v, E0, "fwd_x0"};
        v = z; v.rww = 1; v.rdw = 6; v.rs2e = 6;
        tbl[3] = '{v, mk(2'b00, 2'b01, 4'h0, 3'b000, 0), "fwdB_w"};
        v = z; v.rwm = 1; v.rdm = 3; v.rww = 1; v.rdw = 3;
        v.rs1e = 3; v.rs2e = 3;
        tbl[4] = '{v, mk(2'b10, 2'b10, 4'h0, 3'b000, 0), "fwd_both_m"};
        v = z; v.rdm = 4; v.rs1e = 4;
        tbl[5] = '{v, E0, "fwd_no_we"};
        v = z; v.rse = 2'b01; v.rde = 7; v.rs2d = 7;
        tbl[6] = '{v, LW, "lw_rs2"};
        v = z; v.rse = 2'b01;
        tbl[7] = '{v, E0, "lw_rd0"};
        v = z; v.rse = 2'b01; v.rde = 9; v.rs1d = 9;
        tbl[8] = '{v, LW, "lw_rs1"};
        v = z; v.rde = 7; v.rs1d = 7;
        tbl[9] = '{v, E0, "no_load"};
        v = z; v.pcs = 1;
        tbl[10] = '{v, BR, "branch"};
        v = z; v.req = 1; v.rdy = 1;
        tbl[11] = '{v, E0, "mem_ready_now"};

        drive(z);
        do_reset("rst0");
        for (int k = 0; k < 12; k++) begin
            apply(tbl[k].i, tbl[k].e, tbl[k].n);
        end
        apply(z, E0, "branch_one_cycle");
        drain();

        // 3-cycle memory wait, branch and load-use masked until release
        do_reset("rst1");
        v = z; v.req = 1;
        apply(v, ST, "wait1");
        v.pcs = 1;
        apply(v, ST, "wait2_br_masked");
        v.pcs = 0; v.rse = 2'b01; v.rde = 7; v.rs1d = 7;
        apply(v, ST, "wait3_lw_masked");
        v = z; v.req = 1; v.rdy = 1; v.pcs = 1;
        apply(v, BR, "release_branch");
        apply(z, E0, "after_release");
        drain();
`ifdef HAZARD_PERF_EN
        chk("perf_stall", PerfStall, 32'd3);
        chk("perf_flush", PerfFlush, 32'd1);
`else
        chk("perf_stall", PerfStall, 32'd0);
        chk("perf_flush", PerfFlush, 32'd0);
`endif

        // reset in the middle of a wait abandons it
        v = z; v.req = 1;
        apply(v, ST, "midwait");
        drain();
        do_reset("rst_mid");
        apply(z, E0, "midwait_idle");
        v = z; v.req = 1; v.rdy = 1;
        apply(v, E0, "midwait_fresh");
        drain();

        // timeout after four wait cycles, no exit but reset
        do_reset("rst2");
        v = z; v.req = 1;
        for (int k = 0; k < 4; k++) begin
            apply(v, ST, "to_wait");
        end
        apply(v, mk(2'b00, 2'b00, 4'b1111, 3'b001, 1), "to_err");
        v.rdy = 1;
        apply(v, mk(2'b00, 2'b00, 4'b1111, 3'b001, 1), "err_ready");
        apply(z, mk(2'b00, 2'b00, 4'b1111, 3'b001, 1), "err_sticky");
        drain();
        do_reset("rst_err");
        apply(z, E0, "err_cleared");
        v = z; v.req = 1; v.rdy = 1;
        apply(v, E0, "err_idle");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
